fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] must be 00).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req_o  output  1  instruction-memory request valid.
REQ-005 SHALL have port imem_addr_o  output  32  request byte address, word-aligned.
REQ-006 SHALL have port imem_gnt_i  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_rvalid_i  input  1  read data valid; one per granted request, at least 1 cycle after grant.
REQ-008 SHALL have port imem_rdata_i  input  32  instruction word.
REQ-009 SHALL have port redirect_i  input  1  branch/jump redirect.
REQ-010 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-011 SHALL have port id_valid_o  output  1  instruction available to decode.
REQ-012 SHALL have port id_ready_i  input  1  decode accepts instruction.
REQ-013 SHALL have port id_instr_o  output  32  instruction word (feeds decode and immediate generation).
REQ-014 SHALL have port id_pc_o  output  32  address of id_instr_o.
REQ-015 SHALL have port id_illegal_o  output  1  id_instr_o[1:0] != 2'b11 (not a 32-bit encoding).

Function
REQ-016 SHALL hold pc_q (next fetch address), inflight_pc, kill flag, one output slot (valid/instr/pc), and FSM states REQ and WAIT.
REQ-017 SHALL drive imem_req_o = (state==REQ) && !redirect_i && (!id_valid_o || id_ready_i); imem_addr_o = pc_q.
REQ-018 SHALL on imem_req_o && imem_gnt_i: inflight_pc <= pc_q, pc_q <= pc_q + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), state <= WAIT.
REQ-019 SHALL keep at most one request outstanding; no request in WAIT.
REQ-020 SHALL in WAIT on imem_rvalid_i with kill==0 and no redirect_i: load slot with imem_rdata_i, inflight_pc, valid=1; state <= REQ.
REQ-021 SHALL in WAIT on imem_rvalid_i with kill==1: discard data, clear kill, state <= REQ, slot unchanged.
REQ-022 SHALL clear id_valid_o on id_valid_o && id_ready_i unless refilled same cycle (REQ-020 only, since one outstanding).
REQ-023 SHALL keep id_instr_o/id_pc_o stable while id_valid_o && !id_ready_i.
REQ-024 SHALL on redirect_i (highest priority, any state): pc_q <= {redirect_pc_i[31:2],2'b00}; id_valid_o <= 0.
REQ-025 SHALL on redirect_i in WAIT without imem_rvalid_i: kill <= 1, stay WAIT.
REQ-026 SHALL on redirect_i in WAIT with imem_rvalid_i: discard data, kill <= 0, state <= REQ.
REQ-027 SHALL treat redirect_i while kill==1 as REQ-025 (kill stays 1, target updated).
REQ-028 SHALL sustain one instruction per 2 cycles with 1-cycle grant and 1-cycle response latency.
REQ-029 SHALL derive id_illegal_o combinationally from the slot instruction.

Reset
REQ-030 SHALL, while rst high, asynchronously set pc_q=RESET_PC, inflight_pc=0, kill=0, state=REQ, id_valid_o=0, id_instr_o=0, id_pc_o=0.
REQ-031 SHALL assert imem_req_o in first cycle after rst deasserts (address RESET_PC).
REQ-032 SHALL treat rst mid-request as abandoning it; a response arriving after reset while in REQ SHALL be ignored.

Verification
REQ-033 SHALL cover reset then gnt=1, rvalid next cycle with 32'h0000_0513, ready=1 -> id_pc_o 0, then 4, 8 in sequence, illegal=0.
REQ-034 SHALL cover ready=0 hold: slot holds 0x0 instruction, imem_req_o stays 0, outputs stable 5 cycles; ready=1 -> next request at 0x4.
REQ-035 SHALL cover redirect to 32'h0000_0103 while WAIT, rvalid 2 cycles later -> data dropped, next request address 0x0000_0100, id_pc_o 0x100.
REQ-036 SHALL cover redirect same cycle as rvalid -> no id_valid_o, next request at target.
REQ-037 SHALL cover pc_q=32'hFFFF_FFFC fetch -> next address 32'h0000_0000.
REQ-038 SHALL cover rdata 32'h0000_0001 -> id_illegal_o=1; rst asserted mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// a single-entry output slot toward decode, and redirect with in-flight kill.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_illegal_o
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inflight_pc;
    logic [31:0] w_inflight_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_slot_pc;
    logic [31:0] w_slot_pc_nxt;

    logic        w_req;
    logic        w_fire;
    logic        w_hs;
    logic        w_resp;
    logic [31:0] w_redirect_pc;

    // A new request needs an idle memory port and room in the slot at
    // the next edge (empty now, or being drained this cycle).
    assign w_req  = (r_state == S_REQ) && !redirect_i
                    && (!r_valid || id_ready_i);
    assign w_fire = w_req && imem_gnt_i;
    assign w_hs   = r_valid && id_ready_i;
    assign w_resp = (r_state == S_WAIT) && imem_rvalid_i;

    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign id_valid_o   = r_valid;
    assign id_instr_o   = r_instr;
    assign id_pc_o      = r_slot_pc;
    assign id_illegal_o = (r_instr[1:0] != 2'b11);

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_inflight_pc_nxt = r_inflight_pc;
        w_kill_nxt        = r_kill;
        w_valid_nxt       = r_valid;
        w_instr_nxt       = r_instr;
        w_slot_pc_nxt     = r_slot_pc;

        if (w_hs) begin
            w_valid_nxt = 1'b0;
        end

        unique case (r_state)
            S_REQ: begin
                if (w_fire) begin
                    w_inflight_pc_nxt = r_pc;
                    w_pc_nxt          = r_pc + PC_STEP;
                    w_state_nxt       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp) begin
                    w_state_nxt = S_REQ;
                    w_kill_nxt  = 1'b0;
                    if (!r_kill && !redirect_i) begin
                        w_valid_nxt   = 1'b1;
                        w_instr_nxt   = imem_rdata_i;
                        w_slot_pc_nxt = r_inflight_pc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        // Redirect overrides everything; a fetch still in flight is
        // marked so its response is dropped when it eventually returns.
        if (redirect_i) begin
            w_pc_nxt    = w_redirect_pc;
            w_valid_nxt = 1'b0;
            if ((r_state == S_WAIT) && !imem_rvalid_i) begin
                w_kill_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'h0;
            r_kill        <= 1'b0;
            r_valid       <= 1'b0;
            r_instr       <= 32'h0;
            r_slot_pc     <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_valid       <= w_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_slot_pc     <= w_slot_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then randomized memory/decode
// traffic checked against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_illegal_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .id_illegal_o (id_illegal_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h7F4A_7C15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let outputs settle.
    task automatic drv(input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic red, input logic [31:0] rpc,
                       input logic rdy);
        @(negedge clk);
        rst           = 1'b0;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        redirect_i    = red;
        redirect_pc_i = rpc;
        id_ready_i    = rdy;
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        id_ready_i    = 1'b0;
        #1;
        chk({tag, "_valid"}, id_valid_o, 0);
        chk({tag, "_instr"}, id_instr_o, 0);
        chk({tag, "_pc"}, id_pc_o, 0);
        chk({tag, "_addr"}, imem_addr_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
    endtask

    // Reference model state (transaction level)
    logic        m_pend;
    logic [31:0] m_pend_addr;
    int          m_lat;
    logic        m_kill;
    logic        m_valid;
    logic [31:0] m_slot_pc;
    logic [31:0] m_next;

    initial begin
        logic        r_gnt;
        logic        r_rv;
        logic [31:0] r_rd;
        logic        r_red;
        logic [31:0] r_rpc;
        logic        r_rdy;
        logic        exp_req;
        logic [31:0] exp_instr;

        // Steady stream of 0x513 at two cycles per instruction
        do_reset("rst0");
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk("seq_req", imem_req_o, 1);
            chk("seq_addr", imem_addr_o, 32'(4 * k));
            if (k > 0) begin
                chk("seq_valid", id_valid_o, 1);
                chk("seq_pc", id_pc_o, 32'(4 * (k - 1)));
            end
            drv(1'b0, 1'b1, 32'h0000_0513, 1'b0, 32'h0, 1'b1);
            chk("seq_wait_noreq", imem_req_o, 0);
        end
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("seq_last_valid", id_valid_o, 1);
        chk("seq_last_pc", id_pc_o, 32'h8);
        chk("seq_last_instr", id_instr_o, 32'h0000_0513);
        chk("seq_last_illegal", id_illegal_o, 0);

        // Decode stall holds the slot and blocks new requests
        do_reset("rst1");
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hold_first_addr", imem_addr_o, 32'h0);
        drv(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("hold_req", imem_req_o, 0);
            chk("hold_valid", id_valid_o, 1);
            chk("hold_instr", id_instr_o, 32'h0);
            chk("hold_pc", id_pc_o, 32'h0);
            chk("hold_illegal", id_illegal_o, 1);
        end
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_release_req", imem_req_o, 1);
        chk("hold_release_addr", imem_addr_o, 32'h4);

        // Redirect while waiting; late response is dropped
        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
        chk("kill_req", imem_req_o, 0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("kill_wait_valid", id_valid_o, 0);
        chk("kill_wait_req", imem_req_o, 0);
        drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk("kill_resp_req", imem_req_o, 0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("kill_drop_valid", id_valid_o, 0);
        chk("kill_target_req", imem_req_o, 1);
        chk("kill_target_addr", imem_addr_o, 32'h0000_0100);
        drv(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("kill_new_valid", id_valid_o, 1);
        chk("kill_new_pc", id_pc_o, 32'h0000_0100);
        chk("kill_new_instr", id_instr_o, 32'h0000_0013);

        // Redirect coinciding with the response
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("same_req_addr", imem_addr_o, 32'h0000_0104);
        drv(1'b0, 1'b1, 32'h0000_0013, 1'b1, 32'h0000_0200, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("same_valid", id_valid_o, 0);
        chk("same_req", imem_req_o, 1);
        chk("same_addr", imem_addr_o, 32'h0000_0200);

        // Top-of-memory fetch wraps, and a non-32-bit encoding
        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("wrap_redir_req", imem_req_o, 0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        drv(1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_illegal", id_illegal_o, 1);
        chk("wrap_req", imem_req_o, 1);
        chk("wrap_addr_zero", imem_addr_o, 32'h0);

        // Reset while a fetch is outstanding; stale response ignored
        do_reset("rst_mid");
        drv(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
        chk("post_rst_req", imem_req_o, 1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("stale_valid", id_valid_o, 0);

        // Randomized traffic against the reference model
        m_pend      = 1'b0;
        m_pend_addr = 32'h0;
        m_lat       = 0;
        m_kill      = 1'b0;
        m_valid     = 1'b0;
        m_slot_pc   = 32'h0;
        m_next      = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_gnt = 1'($urandom_range(0, 1));
            r_red = ($urandom_range(0, 9) == 0);
            r_rpc = $urandom;
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rv  = m_pend && (m_lat == 0);
            r_rd  = r_rv ? mem_word(m_pend_addr) : $urandom;
            drv(r_gnt, r_rv, r_rd, r_red, r_rpc, r_rdy);

            exp_req = !m_pend && !r_red && (!m_valid || r_rdy);
            chk("rnd_req", imem_req_o, 32'(exp_req));
            chk("rnd_valid", id_valid_o, 32'(m_valid));
            if (exp_req) begin
                chk("rnd_addr", imem_addr_o, m_next);
            end
            if (m_valid) begin
                exp_instr = mem_word(m_slot_pc);
                chk("rnd_pc", id_pc_o, m_slot_pc);
                chk("rnd_instr", id_instr_o, exp_instr);
                chk("rnd_illegal", id_illegal_o,
                    32'(exp_instr[1:0] != 2'b11));
            end

            if (m_valid && r_rdy) begin
                m_valid = 1'b0;
            end
            if (m_pend && !r_rv) begin
                m_lat--;
            end
            if (r_rv) begin
                m_pend = 1'b0;
                if (!m_kill && !r_red) begin
                    m_valid   = 1'b1;
                    m_slot_pc = m_pend_addr;
                end
                m_kill = 1'b0;
            end
            if (r_red) begin
                m_next  = {r_rpc[31:2], 2'b00};
                m_valid = 1'b0;
                if (m_pend) begin
                    m_kill = 1'b1;
                end
            end else if (exp_req && r_gnt) begin
                m_pend      = 1'b1;
                m_pend_addr = m_next;
                m_next      = m_next + 32'd4;
                m_lat       = $urandom_range(0, 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
